sr_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of the behavioural SR flip-flop and drives its S and R inputs. It accepts set/reset/toggle/resync commands over a valid/ready handshake and buffers them in a small FIFO. Each command becomes a legal S/R pulse; S=R=1 is never issued. After each pulse it reads back the flip-flop's Q and flags any mismatch against the expected value.

---
 rtl/sr_seq_pkg.sv | 29 ++
 rtl/sr_cmd_fifo.sv | 49 ++++
 rtl/sr_cmd_sequencer.sv | 105 ++++++++++
 tb/tb_sr_cmd_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_seq_pkg.sv
// rtl/sr_seq_pkg.sv - op/state encodings and S/R load helper for the SR command sequencer
// Contents: OP_W, OP_* op codes, ST_* FSM states, op_load() returning {s, r, exp}.
package sr_seq_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_RESYNC = 2'b00;
  localparam logic [OP_W-1:0] OP_SET    = 2'b01;
  localparam logic [OP_W-1:0] OP_RESET  = 2'b10;
  localparam logic [OP_W-1:0] OP_TOGGLE = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  // Drive pattern for an op given the currently expected Q.
  // Toggle drives S=~q, R=q, so S and R can never both be 1.
  function automatic logic [2:0] op_load(input logic [OP_W-1:0] op, input logic q_exp);
    logic [2:0] res;
    case (op)
      OP_SET:    res = 3'b101;
      OP_RESET:  res = 3'b010;
      OP_TOGGLE: res = {~q_exp, q_exp, ~q_exp};
      default:   res = {2'b00, q_exp};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// rtl/sr_cmd_fifo.sv - DEPTH x OP_W command FIFO with pointer-plus-wrap-bit full/empty
// Ports: clk, rst_n (async active-low), wr_en/wr_data push, rd_en pop,
//        rd_data head entry, full, empty (both from registered pointers only).
module sr_cmd_fifo
  import sr_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [OP_W-1:0] wr_data,
  input  logic            rd_en,
  output logic [OP_W-1:0] rd_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [OP_W-1:0] mem [DEPTH];
  logic            push;
  logic            pop;

  // full gates the push even when a pop happens in the same cycle.
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - command front-end driving legal S/R pulses into an SR flip-flop
// Ports: clk, rst_n (async active-low); cmd_valid/cmd_ready/cmd_op command handshake;
//        S/R registered flip-flop drives; Q flip-flop feedback; busy; mismatch (sticky);
//        cmd_count completed commands (wraps).
module sr_cmd_sequencer
  import sr_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  output logic            S,
  output logic            R,
  input  logic            Q,
  output logic            busy,
  output logic            mismatch,
  output logic [7:0]      cmd_count
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  logic            fifo_full;
  logic            fifo_empty;
  logic [OP_W-1:0] head_op;
  logic            pop;
  logic [1:0]      state;
  logic [3:0]      hold_cnt;
  logic [OP_W-1:0] cur_op;
  logic            exp_val;
  logic            q_exp;
  logic [2:0]      load;

  sr_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cmd_valid),
    .wr_data (cmd_op),
    .rd_en   (pop),
    .rd_data (head_op),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign load      = op_load(head_op, q_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      cur_op    <= OP_RESYNC;
      exp_val   <= 1'b0;
      q_exp     <= 1'b0;
      mismatch  <= 1'b0;
      cmd_count <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_op   <= head_op;
            S        <= load[2];
            R        <= load[1];
            exp_val  <= load[0];
            hold_cnt <= HOLD_LOAD;
            state    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (hold_cnt == 4'd0) begin
            S     <= 1'b0;
            R     <= 1'b0;
            state <= ST_CHECK;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          // Resync adopts whatever the flip-flop holds; it never flags.
          if (cur_op == OP_RESYNC) begin
            q_exp <= Q;
          end else begin
            if (Q != exp_val) mismatch <= 1'b1;
            q_exp <= exp_val;
          end
          cmd_count <= cmd_count + 8'd1;
          state     <= ST_IDLE;
        end
        default: begin
          S     <= 1'b0;
          R     <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb/tb_sr_cmd_sequencer.sv - scoreboard bench for sr_cmd_sequencer with a behavioural SR flip-flop
module tb_sr_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       S;
  logic       R;
  logic       Q;
  logic       busy;
  logic       mismatch;
  logic [7:0] cmd_count;

  logic ff;
  logic stuck_en;
  logic stuck_val;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       s;
    logic       r;
    logic [7:0] cnt;
    logic       mm;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic m_ff;
  logic m_qexp;
  logic m_mm;
  int   m_cnt;

  always #5 clk = ~clk;

  sr_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .S         (S),
    .R         (R),
    .Q         (Q),
    .busy      (busy),
    .mismatch  (mismatch),
    .cmd_count (cmd_count)
  );

  // Behavioural SR flip-flop downstream of the sequencer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ff <= 1'b0;
    else if (S)  ff <= 1'b1;
    else if (R)  ff <= 1'b0;
  end
  assign Q = stuck_en ? stuck_val : ff;

  a_no_sr: assert property (@(posedge clk) !(S && R));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_ff   = 1'b0;
    m_qexp = 1'b0;
    m_mm   = 1'b0;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  // What each op does to the flip-flop and to the sequencer's bookkeeping.
  task automatic model_push(input logic [1:0] op);
    exp_t e;
    logic s, r, want, qobs;
    case (op)
      2'b01:   begin s = 1'b1;    r = 1'b0;   want = 1'b1;    end
      2'b10:   begin s = 1'b0;    r = 1'b1;   want = 1'b0;    end
      2'b11:   begin s = !m_qexp; r = m_qexp; want = !m_qexp; end
      default: begin s = 1'b0;    r = 1'b0;   want = m_qexp;  end
    endcase
    if (s) m_ff = 1'b1;
    else if (r) m_ff = 1'b0;
    qobs = stuck_en ? stuck_val : m_ff;
    if (op == 2'b00) begin
      m_qexp = qobs;
    end else begin
      if (qobs != want) m_mm = 1'b1;
      m_qexp = want;
    end
    m_cnt = (m_cnt + 1) % 256;
    e.s = s; e.r = r; e.cnt = 8'(m_cnt); e.mm = m_mm;
    exp_q.push_back(e);
  endtask

  // Call at a negedge; returns at a negedge after acceptance.
  task automatic push(input logic [1:0] op, output int waited);
    waited = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    while (!cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(waited), 32'd0);
    end else begin
      model_push(op);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("drain_bounded", 32'(t < 2000), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    stuck_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic monitor();
    logic       in_pulse = 1'b0;
    logic       pulse_seen = 1'b0;
    logic       ps = 1'b0, pr = 1'b0;
    int         plen = 0;
    logic [7:0] last_cnt = 8'd0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pulse = 1'b0; pulse_seen = 1'b0; plen = 0; last_cnt = 8'd0;
      end else begin
        chk("s_and_r_exclusive", 32'(S && R), 32'd0);
        if (S || R) begin
          if (!in_pulse) begin
            ps = S; pr = R; plen = 0;
          end else if (S != ps || R != pr) begin
            chk("pulse_stable", {30'd0, S, R}, {30'd0, ps, pr});
          end
          in_pulse = 1'b1;
          plen++;
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          pulse_seen = 1'b1;
        end
        if (cmd_count != last_cnt) begin
          last_cnt = cmd_count;
          chk("completion_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("cmd_count", 32'(cmd_count), 32'(e.cnt));
            chk("mismatch", 32'(mismatch), 32'(e.mm));
            chk("pulse_present", 32'(pulse_seen), 32'(e.s || e.r));
            if (e.s || e.r) begin
              chk("pulse_sr", {30'd0, ps, pr}, {30'd0, e.s, e.r});
              chk("pulse_len", 32'(plen), 32'(HOLD));
            end
          end
          pulse_seen = 1'b0;
        end
      end
    end
  endtask

  task automatic stimulus();
    int w;
    int waits[7];
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s", 32'(S), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);

    // Resync then set
    push(2'b00, w);
    push(2'b01, w);
    drain();
    chk("set_q", 32'(Q), 32'd1);
    chk("set_mismatch", 32'(mismatch), 32'd0);
    chk("set_count", 32'(cmd_count), 32'd2);

    // Set, toggle, toggle
    push(2'b01, w);
    push(2'b11, w);
    push(2'b11, w);
    drain();
    chk("toggle_q", 32'(Q), 32'd1);
    chk("toggle_count", 32'(cmd_count), 32'd5);

    // Back-to-back burst: with HOLD=1 the first six go straight in, the seventh sees full
    for (int i = 0; i < 7; i++) begin
      push(2'($urandom_range(0, 3)), w);
      waits[i] = w;
    end
    for (int i = 0; i < 6; i++) chk("burst_no_wait", 32'(waits[i]), 32'd0);
    chk("burst_full_stall", 32'(waits[6] > 0), 32'd1);
    drain();

    // Q stuck at 0: set must flag, flag stays through correct commands, reset clears it
    stuck_val = 1'b0;
    stuck_en = 1'b1;
    push(2'b01, w);
    drain();
    chk("stuck_mismatch", 32'(mismatch), 32'd1);
    stuck_en = 1'b0;
    push(2'b01, w);
    push(2'b10, w);
    push(2'b11, w);
    drain();
    chk("sticky_mismatch", 32'(mismatch), 32'd1);
    do_reset();
    chk("mismatch_cleared", 32'(mismatch), 32'd0);

    // Reset mid-DRIVE with commands still queued
    push(2'b01, w);
    push(2'b10, w);
    push(2'b01, w);
    push(2'b11, w);
    t = 0;
    while (!(S || R) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drive_seen", 32'(S || R), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_s", 32'(S), 32'd0);
    chk("async_r", 32'(R), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_count", 32'(cmd_count), 32'd0);
    chk("async_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Counter wrap
    for (int i = 0; i < 256; i++) push(2'b00, w);
    drain();
    chk("count_wrap", 32'(cmd_count), 32'd0);

    // Random ops with random gaps
    for (int i = 0; i < 60; i++) begin
      push(2'($urandom_range(0, 3)), w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    chk("final_count", 32'(cmd_count), 32'(m_cnt));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    stuck_en = 1'b0;
    stuck_val = 1'b0;
    model_reset();
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
